// File: rtl/stencil3d_stream_if.sv
// Stream bundle for stencil3d_stream: valid/ready element input and
// valid/ready result output. The engine takes the slave view, the
// loader/collector side takes the master view.
interface stencil3d_stream_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stencil3d_stream.sv
// Streaming 7-point 3D stencil engine.
// Loads ROW_SIZE*COL_SIZE*HEIGHT_SIZE elements in raster order, then emits
// sol = c0*centre + c1*(sum of 6 neighbours) per point in raster order,
// with zero for boundary points. Two-stage compute pipeline with
// backpressure from out_ready.
// Optional build macro STENCIL3D_SAT_EN: full-width arithmetic with the
// result clamped to 2^DATA_W-1 instead of modulo wrap-around.
module stencil3d_stream #(
  parameter int DATA_W      = 32,
  parameter int ROW_SIZE    = 16,
  parameter int COL_SIZE    = 32,
  parameter int HEIGHT_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] c0,
  input  logic [DATA_W-1:0] c1,
  output logic              busy,
  output logic              done,
  stencil3d_stream_if.slave s
);

  localparam int SIZE  = ROW_SIZE * COL_SIZE * HEIGHT_SIZE;
  localparam int IDX_W = $clog2(SIZE);
  localparam int KW    = $clog2(ROW_SIZE);
  localparam int JW    = $clog2(COL_SIZE);
  localparam int IW    = $clog2(HEIGHT_SIZE);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);
  localparam logic [IDX_W-1:0] STEP_K   = IDX_W'(1);
  localparam logic [IDX_W-1:0] STEP_J   = IDX_W'(ROW_SIZE);
  localparam logic [IDX_W-1:0] STEP_I   = IDX_W'(ROW_SIZE * COL_SIZE);
  localparam logic [KW-1:0]    K_MAX    = KW'(ROW_SIZE - 1);
  localparam logic [JW-1:0]    J_MAX    = JW'(COL_SIZE - 1);
  localparam logic [IW-1:0]    I_MAX    = IW'(HEIGHT_SIZE - 1);

`ifdef STENCIL3D_SAT_EN
  // Neighbour sum keeps 3 guard bits so six addends never wrap.
  localparam int S1_W = DATA_W + 3;
  localparam int P_W  = 2 * DATA_W + 3;

  function automatic logic [DATA_W-1:0] sat_clamp(input logic [P_W-1:0] v);
    return (v > P_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
  endfunction
`else
  localparam int S1_W = DATA_W;
`endif

  function automatic logic [DATA_W-1:0] combine(input logic [DATA_W-1:0] s0,
                                                input logic [S1_W-1:0]   s1,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
`ifdef STENCIL3D_SAT_EN
    return sat_clamp(P_W'(s0) * P_W'(a) + P_W'(s1) * P_W'(b));
`else
    return s0 * a + s1 * b;
`endif
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [SIZE];
  logic [IDX_W-1:0]  load_cnt;
  logic [IDX_W-1:0]  iss_idx;
  logic [KW-1:0]     k_cnt;
  logic [JW-1:0]     j_cnt;
  logic [IW-1:0]     i_cnt;
  logic [DATA_W-1:0] c0_q;
  logic [DATA_W-1:0] c1_q;

  logic              bnd;
  logic [S1_W-1:0]   nsum;
  logic              adv;
  logic              issue;

  logic [DATA_W-1:0] sum0_p1;
  logic [S1_W-1:0]   sum1_p1;
  logic              vld_p1;
  logic              last_p1;

  // Pipeline moves whenever the output register is empty or being drained.
  assign adv   = !s.out_valid || s.out_ready;
  assign issue = (state == COMPUTE) && adv;

  // Element buffer: written during LOAD only, never cleared.
  always_ff @(posedge clk) begin
    if (s.in_valid && s.in_ready) mem[load_cnt] <= s.in_data;
  end

  // Coefficients captured when a job is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      c0_q <= c0;
      c1_q <= c1;
    end
  end

  // Stage 0 -> 1: boundary detect and neighbour fetch for the issued point.
  always_comb begin
    bnd  = (k_cnt == '0) || (k_cnt == K_MAX) ||
           (j_cnt == '0) || (j_cnt == J_MAX) ||
           (i_cnt == '0) || (i_cnt == I_MAX);
    nsum = S1_W'(mem[iss_idx - STEP_K]) + S1_W'(mem[iss_idx + STEP_K]) +
           S1_W'(mem[iss_idx - STEP_J]) + S1_W'(mem[iss_idx + STEP_J]) +
           S1_W'(mem[iss_idx - STEP_I]) + S1_W'(mem[iss_idx + STEP_I]);
  end

  // Stage 1 data: boundary points carry zero sums so the product is zero.
  always_ff @(posedge clk) begin
    if (issue) begin
      sum0_p1 <= bnd ? '0 : mem[iss_idx];
      sum1_p1 <= bnd ? '0 : nsum;
    end
  end

  // Control FSM, counters and the valid/last/result pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      s.in_ready  <= 1'b0;
      load_cnt    <= '0;
      iss_idx     <= '0;
      k_cnt       <= '0;
      j_cnt       <= '0;
      i_cnt       <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_last  <= 1'b0;
      s.out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            s.in_ready <= 1'b1;
            load_cnt   <= '0;
          end
        end
        LOAD: begin
          if (s.in_valid && s.in_ready) begin
            if (load_cnt == IDX_LAST) begin
              state      <= COMPUTE;
              s.in_ready <= 1'b0;
              iss_idx    <= '0;
              k_cnt      <= '0;
              j_cnt      <= '0;
              i_cnt      <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (adv) begin
            if (iss_idx == IDX_LAST) begin
              state <= DRAIN;
            end else begin
              iss_idx <= iss_idx + 1'b1;
              if (k_cnt == K_MAX) begin
                k_cnt <= '0;
                if (j_cnt == J_MAX) begin
                  j_cnt <= '0;
                  i_cnt <= i_cnt + 1'b1;
                end else begin
                  j_cnt <= j_cnt + 1'b1;
                end
              end else begin
                k_cnt <= k_cnt + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (s.out_valid && s.out_ready && s.out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Stage 1 -> 2: the output register holds while stalled.
      if (adv) begin
        vld_p1      <= issue;
        last_p1     <= issue && (iss_idx == IDX_LAST);
        s.out_valid <= vld_p1;
        s.out_last  <= last_p1;
        if (vld_p1) s.out_data <= combine(sum0_p1, sum1_p1, c0_q, c1_q);
      end
    end
  end

endmodule

// File: doc/stencil3d_stream.md
Name: stencil3d_stream

Overview:
- Parametrised, streaming 7-point 3D stencil engine; next generation of the fixed 16x32x32 stencil3d.
- Loads a grid over a valid/ready input stream into an internal buffer, then computes sol = C0*centre + C1*(sum of 6 neighbours).
- Emits one result per cycle, in raster order, over a valid/ready output stream.
- Sits between the MachSuite DMA/loader and the result collector.

Parameters:
- DATA_W, 32, element and coefficient width (unsigned)
- ROW_SIZE, 16, extent of fastest-varying index k (>=3)
- COL_SIZE, 32, extent of index j (>=3)
- HEIGHT_SIZE, 32, extent of slowest index i (>=3)
- SIZE, ROW_SIZE*COL_SIZE*HEIGHT_SIZE, derived local; total points
- IDX_W, clog2(SIZE), derived local; address/counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a job when IDLE
- c0  in  DATA_W  centre coefficient; sampled on accepted start
- c1  in  DATA_W  neighbour coefficient; sampled on accepted start
- in_valid  in  1  input element valid
- in_ready  out  1  engine accepts input (high only in LOAD)
- in_data  in  DATA_W  element, raster order: idx = k + ROW_SIZE*(j + COL_SIZE*i)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  result for point idx, raster order
- out_last  out  1  high with the final (idx=SIZE-1) result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last result is accepted

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0; counters=0. Buffer contents are undefined after reset and are not cleared.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE: start=1 latches c0/c1 and moves to LOAD next cycle. start in any other state is ignored.
- LOAD: in_ready=1. Each in_valid&&in_ready handshake writes buf[load_cnt] and increments load_cnt. The handshake with load_cnt=SIZE-1 moves to COMPUTE. No timeout; stalls indefinitely if in_valid stays low.
- COMPUTE: two-stage pipeline, one point index issued per cycle when not stalled.
  - Stage 1: read centre and 6 neighbours combinationally from buf; register sum0 and sum1.
  - Stage 2: out_data <= sum0*c0 + sum1*c1; out_valid <= 1.
  - Latency: first out_valid asserts 2 cycles after entering COMPUTE.
  - Stall: pipeline advances only when out_valid==0 or out_ready==1. While out_valid=1 and out_ready=0, out_data/out_valid/out_last hold stable.
  - After issuing idx=SIZE-1, move to DRAIN.
- DRAIN: wait for the handshake with out_last=1. Then pulse done for 1 cycle, return to IDLE, and drop busy in the same cycle as done.
- Boundary points (k, j or i equal to 0 or max) produce out_data=0 and are still emitted, so exactly SIZE results per job.
- Arithmetic (default): unsigned, all sums and products modulo 2^DATA_W, matching the fixed-width stencil3d.
- Simultaneous events: a handshake on the last result and start in the same cycle ignores start, because the state is not IDLE.
- Mid-operation reset: abandons the job, applies reset values; the next start begins a fresh LOAD.
- out_last is asserted only with out_valid.

Optional Feature:
- Macro: STENCIL3D_SAT_EN.
- Defined: sum1, products and final sum are computed at full width (DATA_W+3, 2*DATA_W+3 bits), then the result is clamped to 2^DATA_W-1 if it exceeds that value.
- Undefined: wrap-around modulo 2^DATA_W, as above.
- Boundary zeros and timing are identical in both builds.

Test Plan:
- Config ROW=COL=HEIGHT=4, all inputs 1, c0=2, c1=3 -> 64 results; the 8 interior points =20, boundary =0; out_last on result 63; done pulses once.
- Same config, in_data=idx (0..63), c0=1, c1=1 -> interior point idx 21 = 21+(22+20+25+17+37+5) = 147.
- out_ready toggled with pattern 1,0,0,1 during COMPUTE -> no result dropped or duplicated; out_data stable while stalled; in-order sequence matches the unstalled run.
- DATA_W=8, all inputs 200, c0=1, c1=1 -> interior 200+1200=1400 gives 120 (wrap) without macro, 255 with STENCIL3D_SAT_EN.
- Assert rst mid-COMPUTE after 10 results -> out_valid=0 and busy=0 immediately; a new start with fresh data gives correct full results.
- start pulsed during LOAD and during COMPUTE -> ignored; exactly one job of SIZE results completes.
